// File: rtl/rec_transport_ctrl.sv
// Transport controller for the audio recorder: owns the shared SRAM sample
// address and sequences record, play and pause from the debounced buttons.
module rec_transport_ctrl #(
  parameter int                ADDR_W   = 18,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 18'h3FFFF,
  parameter int                MAX_RATE = 8,
  parameter bit                LOOP     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_record,
  input  logic              btn_play,
  input  logic              btn_stop,
  input  logic              btn_faster,
  input  logic              btn_slower,
  input  logic              btn_method,
  input  logic              sample_tick,
  output logic              record,
  output logic              play,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] end_addr,
  output logic              full,
  output logic [3:0]        slow,
  output logic [3:0]        fast,
  output logic              slowmethod,
  output logic [3:0]        phase,
  output logic [1:0]        state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REC   = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  localparam logic signed [4:0] IDX_MAX = 5'(MAX_RATE - 1);
  localparam logic signed [4:0] IDX_MIN = -IDX_MAX;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0] END_EXT =
    {1'b0, MAX_ADDR} + {{ADDR_W{1'b0}}, 1'b1};
  // A full recording of the whole SRAM saturates instead of wrapping to 0.
  localparam logic [ADDR_W-1:0] END_FULL =
    END_EXT[ADDR_W] ? '1 : END_EXT[ADDR_W-1:0];

  function automatic logic [3:0] slow_of(input logic signed [4:0] i);
    logic [4:0] m;
    m = i[4] ? 5'(-i) : 5'd0;
    return 4'(m + 5'd1);
  endfunction

  function automatic logic [3:0] fast_of(input logic signed [4:0] i);
    return i[4] ? 4'd1 : 4'($unsigned(i) + 5'd1);
  endfunction

  logic [5:0] btn;
  logic [5:0] prev_q;
  logic [5:0] rise;
  logic       r_rec;
  logic       r_play;
  logic       r_stop;
  logic       r_fast;
  logic       r_slow;
  logic       r_meth;

  assign btn = {btn_record, btn_play, btn_stop,
                btn_faster, btn_slower, btn_method};
  assign rise = btn & ~prev_q;
  assign r_rec  = rise[5];
  assign r_play = rise[4];
  assign r_stop = rise[3];
  assign r_fast = rise[2];
  assign r_slow = rise[1];
  assign r_meth = rise[0];

  logic [1:0]        state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [ADDR_W-1:0] end_q, end_n;
  logic              full_q, full_n;
  logic signed [4:0] idx_q, idx_n;
  logic              method_q, method_n;
  logic [3:0]        phase_q, phase_n;

  logic [ADDR_W:0] sum;
  logic [ADDR_W:0] wrap;
  logic            at_end;

  assign slow = slow_of(idx_q);
  assign fast = fast_of(idx_q);

  // One extra bit so a large fast step past end_addr is never lost.
  assign sum    = {1'b0, addr_q} + {{(ADDR_W-3){1'b0}}, fast};
  assign wrap   = sum - {1'b0, end_q};
  assign at_end = sum >= {1'b0, end_q};

  always_comb begin
    state_n  = state_q;
    addr_n   = addr_q;
    end_n    = end_q;
    full_n   = full_q;
    phase_n  = phase_q;
    idx_n    = idx_q;
    method_n = method_q ^ r_meth;

    if (r_fast && !r_slow && idx_q != IDX_MAX) begin
      idx_n = idx_q + 5'sd1;
    end else if (r_slow && !r_fast && idx_q != IDX_MIN) begin
      idx_n = idx_q - 5'sd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!r_stop) begin
          if (r_rec) begin
            state_n = S_REC;
            addr_n  = '0;
            end_n   = '0;
            full_n  = 1'b0;
          end else if (r_play && end_q != '0) begin
            state_n = S_PLAY;
            addr_n  = '0;
            phase_n = '0;
          end
        end
      end
      S_REC: begin
        if (r_stop) begin
          state_n = S_IDLE;
          addr_n  = '0;
        end else if (sample_tick) begin
          if (addr_q == MAX_ADDR) begin
            end_n   = END_FULL;
            full_n  = 1'b1;
            state_n = S_IDLE;
            addr_n  = '0;
          end else begin
            end_n  = addr_q + ONE;
            addr_n = addr_q + ONE;
          end
        end
      end
      S_PLAY: begin
        if (r_stop) begin
          state_n = S_IDLE;
          addr_n  = '0;
          phase_n = '0;
        end else if (r_play) begin
          state_n = S_PAUSE;
        end else if (sample_tick) begin
          if (phase_q < slow - 4'd1) begin
            phase_n = phase_q + 4'd1;
          end else begin
            phase_n = '0;
            if (!at_end) begin
              addr_n = sum[ADDR_W-1:0];
            end else if (LOOP) begin
              addr_n = wrap[ADDR_W-1:0];
            end else begin
              state_n = S_IDLE;
              addr_n  = '0;
            end
          end
        end
      end
      S_PAUSE: begin
        if (r_stop) begin
          state_n = S_IDLE;
          addr_n  = '0;
          phase_n = '0;
        end else if (r_play) begin
          state_n = S_PLAY;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A speed change mid-playback must not leave phase beyond the new slow.
    if (phase_n >= slow_of(idx_n)) begin
      phase_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      end_q    <= '0;
      full_q   <= 1'b0;
      idx_q    <= '0;
      method_q <= 1'b0;
      phase_q  <= '0;
      prev_q   <= btn;
    end else begin
      state_q  <= state_n;
      addr_q   <= addr_n;
      end_q    <= end_n;
      full_q   <= full_n;
      idx_q    <= idx_n;
      method_q <= method_n;
      phase_q  <= phase_n;
      prev_q   <= btn;
    end
  end

  assign record     = state_q == S_REC;
  assign play       = state_q == S_PLAY;
  assign addr       = addr_q;
  assign end_addr   = end_q;
  assign full       = full_q;
  assign slowmethod = method_q;
  assign phase      = phase_q;
  assign state      = state_q;

endmodule

// File: tb/tb_rec_transport_ctrl.sv
// Directed bench for rec_transport_ctrl: two instances (default and a
// small looping one) checked against an expectation queue.
module tb_rec_transport_ctrl;

  localparam logic [6:0] R  = 7'b1000000;
  localparam logic [6:0] P  = 7'b0100000;
  localparam logic [6:0] S  = 7'b0010000;
  localparam logic [6:0] F  = 7'b0001000;
  localparam logic [6:0] SL = 7'b0000100;
  localparam logic [6:0] M  = 7'b0000010;
  localparam logic [6:0] T  = 7'b0000001;

  logic       clk;
  logic       reset;
  logic [1:0] b_rec, b_play, b_stop, b_fast, b_slow, b_meth, tick;

  logic        o_rec   [2];
  logic        o_play  [2];
  logic [17:0] o_addr  [2];
  logic [17:0] o_end   [2];
  logic        o_full  [2];
  logic [3:0]  o_slow  [2];
  logic [3:0]  o_fast  [2];
  logic        o_meth  [2];
  logic [3:0]  o_phase [2];
  logic [1:0]  o_state [2];

  int n_chk;
  int n_fail;

  typedef struct {
    string       tag;
    int          d;
    logic [1:0]  st;
    logic [17:0] a;
    logic [3:0]  ph;
  } exp_t;

  exp_t sb[$];

  rec_transport_ctrl u0 (
    .clk(clk), .reset(reset),
    .btn_record(b_rec[0]), .btn_play(b_play[0]), .btn_stop(b_stop[0]),
    .btn_faster(b_fast[0]), .btn_slower(b_slow[0]),
    .btn_method(b_meth[0]), .sample_tick(tick[0]),
    .record(o_rec[0]), .play(o_play[0]), .addr(o_addr[0]),
    .end_addr(o_end[0]), .full(o_full[0]), .slow(o_slow[0]),
    .fast(o_fast[0]), .slowmethod(o_meth[0]), .phase(o_phase[0]),
    .state(o_state[0])
  );

  rec_transport_ctrl #(.MAX_ADDR(18'd3), .LOOP(1'b1)) u1 (
    .clk(clk), .reset(reset),
    .btn_record(b_rec[1]), .btn_play(b_play[1]), .btn_stop(b_stop[1]),
    .btn_faster(b_fast[1]), .btn_slower(b_slow[1]),
    .btn_method(b_meth[1]), .sample_tick(tick[1]),
    .record(o_rec[1]), .play(o_play[1]), .addr(o_addr[1]),
    .end_addr(o_end[1]), .full(o_full[1]), .slow(o_slow[1]),
    .fast(o_fast[1]), .slowmethod(o_meth[1]), .phase(o_phase[1]),
    .state(o_state[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int d, logic [6:0] v);
    b_rec[d]  = v[6];
    b_play[d] = v[5];
    b_stop[d] = v[4];
    b_fast[d] = v[3];
    b_slow[d] = v[2];
    b_meth[d] = v[1];
    tick[d]   = v[0];
  endtask

  // One stimulus cycle followed by one quiet cycle so the next press
  // of the same button is seen as a fresh edge.
  task automatic step(int d, logic [6:0] v, string tag,
                      logic [1:0] st, logic [17:0] a, logic [3:0] ph);
    exp_t e;
    e.tag = tag;
    e.d   = d;
    e.st  = st;
    e.a   = a;
    e.ph  = ph;
    sb.push_back(e);
    drive(d, v);
    cyc();
    drive(d, 7'd0);
    cyc();
    e = sb.pop_front();
    chk({e.tag, ".state"}, 32'(o_state[e.d]), 32'(e.st));
    chk({e.tag, ".addr"}, 32'(o_addr[e.d]), 32'(e.a));
    chk({e.tag, ".phase"}, 32'(o_phase[e.d]), 32'(e.ph));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    drive(0, 7'd0);
    drive(1, 7'd0);
    reset = 1'b1;
    b_play = 2'b11;
    repeat (3) cyc();
    chk("rst.state", 32'(o_state[0]), 32'd0);
    chk("rst.addr", 32'(o_addr[0]), 32'd0);
    chk("rst.slow", 32'(o_slow[0]), 32'd1);
    chk("rst.fast", 32'(o_fast[0]), 32'd1);
    chk("rst.end", 32'(o_end[0]), 32'd0);
    chk("rst.meth", 32'(o_meth[0]), 32'd0);
    reset = 1'b0;
    cyc();
    chk("held_play.state", 32'(o_state[0]), 32'd0);
    b_play = 2'b00;
    cyc();
    step(0, P, "play_empty", 2'd0, 18'd0, 4'd0);

    step(0, R, "rec_start", 2'd1, 18'd0, 4'd0);
    chk("rec_start.record", 32'(o_rec[0]), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step(0, T, "rec_tick", 2'd1, 18'(i), 4'd0);
    end
    chk("rec5.end", 32'(o_end[0]), 32'd5);
    step(0, S, "rec_stop", 2'd0, 18'd0, 4'd0);
    chk("rec_stop.end", 32'(o_end[0]), 32'd5);
    chk("rec_stop.full", 32'(o_full[0]), 32'd0);

    step(0, P, "play1", 2'd2, 18'd0, 4'd0);
    chk("play1.play", 32'(o_play[0]), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step(0, T, "play1_tick", 2'd2, 18'(i), 4'd0);
    end
    step(0, T, "play1_end", 2'd0, 18'd0, 4'd0);

    step(0, SL, "slower1", 2'd0, 18'd0, 4'd0);
    step(0, SL, "slower2", 2'd0, 18'd0, 4'd0);
    chk("slow3.slow", 32'(o_slow[0]), 32'd3);
    chk("slow3.fast", 32'(o_fast[0]), 32'd1);
    step(0, P, "play_slow", 2'd2, 18'd0, 4'd0);
    for (int k = 1; k <= 7; k++) begin
      step(0, T, "slow_tick", 2'd2, 18'(k / 3), 4'(k % 3));
    end
    step(0, M, "method", 2'd2, 18'd2, 4'd1);
    chk("method.on", 32'(o_meth[0]), 32'd1);
    step(0, F, "live_f1", 2'd2, 18'd2, 4'd1);
    chk("live_f1.slow", 32'(o_slow[0]), 32'd2);
    step(0, F, "live_f2", 2'd2, 18'd2, 4'd0);
    step(0, S, "slow_stop", 2'd0, 18'd0, 4'd0);

    step(0, R, "rec20", 2'd1, 18'd0, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      step(0, T, "rec20_tick", 2'd1, 18'(i), 4'd0);
    end
    step(0, S, "rec20_stop", 2'd0, 18'd0, 4'd0);
    chk("rec20.end", 32'(o_end[0]), 32'd20);
    for (int i = 0; i < 9; i++) begin
      step(0, F, "faster", 2'd0, 18'd0, 4'd0);
    end
    chk("fast_sat.fast", 32'(o_fast[0]), 32'd8);
    chk("fast_sat.slow", 32'(o_slow[0]), 32'd1);
    step(0, P, "play_fast", 2'd2, 18'd0, 4'd0);
    step(0, T, "fast_t1", 2'd2, 18'd8, 4'd0);
    step(0, T, "fast_t2", 2'd2, 18'd16, 4'd0);
    step(0, T, "fast_end", 2'd0, 18'd0, 4'd0);

    for (int i = 0; i < 16; i++) begin
      step(0, SL, "slower", 2'd0, 18'd0, 4'd0);
    end
    chk("slow_sat.slow", 32'(o_slow[0]), 32'd8);
    chk("slow_sat.fast", 32'(o_fast[0]), 32'd1);
    step(0, F | SL, "both_speed", 2'd0, 18'd0, 4'd0);
    chk("both_speed.slow", 32'(o_slow[0]), 32'd8);
    for (int i = 0; i < 7; i++) begin
      step(0, F, "restore", 2'd0, 18'd0, 4'd0);
    end
    chk("restore.slow", 32'(o_slow[0]), 32'd1);

    step(0, P, "pz_play", 2'd2, 18'd0, 4'd0);
    step(0, T, "pz_t1", 2'd2, 18'd1, 4'd0);
    step(0, P, "pz_pause", 2'd3, 18'd1, 4'd0);
    step(0, T, "pz_tick_ign", 2'd3, 18'd1, 4'd0);
    step(0, P | T, "pz_resume", 2'd2, 18'd1, 4'd0);
    step(0, T, "pz_t2", 2'd2, 18'd2, 4'd0);
    step(0, R, "pz_rec_ign", 2'd2, 18'd2, 4'd0);
    step(0, S | R | P, "pz_srp", 2'd0, 18'd0, 4'd0);

    step(1, R, "u1_rec", 2'd1, 18'd0, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1, T, "u1_rec_tick", 2'd1, 18'(i), 4'd0);
    end
    chk("u1_pre.full", 32'(o_full[1]), 32'd0);
    step(1, T, "u1_full", 2'd0, 18'd0, 4'd0);
    chk("u1_full.full", 32'(o_full[1]), 32'd1);
    chk("u1_full.end", 32'(o_end[1]), 32'd4);
    step(1, P, "u1_play", 2'd2, 18'd0, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1, T, "u1_play_tick", 2'd2, 18'(i), 4'd0);
    end
    step(1, T, "u1_wrap", 2'd2, 18'd0, 4'd0);
    step(1, T, "u1_after_wrap", 2'd2, 18'd1, 4'd0);
    step(1, S, "u1_stop", 2'd0, 18'd0, 4'd0);
    step(1, R, "u1_rerec", 2'd1, 18'd0, 4'd0);
    chk("u1_rerec.full", 32'(o_full[1]), 32'd0);
    chk("u1_rerec.end", 32'(o_end[1]), 32'd0);
    step(1, S, "u1_stop2", 2'd0, 18'd0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rec_transport_ctrl.md
Name: rec_transport_ctrl

Overview:
Transport/sequencing controller for the audio recorder. Owns the shared SRAM sample address and decides when ADC recording and DAC playback run. Turns the debounced record/play/stop/speed buttons into a RECORD/PLAY/PAUSE/IDLE state machine. Drives the playback speed configuration (slow, fast, slowmethod) consumed by the DAC path. Sits between the debouncers and the adc/dac/sram blocks, clocked on the 12 MHz PLL clock.

Parameters:
ADDR_W, 18, SRAM word address width
MAX_ADDR, 18'h3FFFF, last writable sample address
MAX_RATE, 8, maximum value of slow and fast
LOOP, 0, 1 = playback wraps to 0 at end_addr; 0 = playback stops

Ports:
clk  in  1  12 MHz system clock
reset  in  1  synchronous, active-high
btn_record  in  1  debounced level
btn_play  in  1  debounced level; toggles play/pause
btn_stop  in  1  debounced level
btn_faster  in  1  debounced level; speed index +1
btn_slower  in  1  debounced level; speed index -1
btn_method  in  1  debounced level; toggles slowmethod
sample_tick  in  1  one-cycle pulse per stereo sample, synchronous to clk
record  out  1  high in REC state
play  out  1  high in PLAY state only
addr  out  ADDR_W  current sample address for sram/adc/dac
end_addr  out  ADDR_W  number of valid recorded samples
full  out  1  recording reached MAX_ADDR
slow  out  4  playback slow factor, 1..MAX_RATE
fast  out  4  playback fast factor, 1..MAX_RATE
slowmethod  out  1  0 = zero-order hold, 1 = first-order
phase  out  4  sub-sample index during slow playback, 0..slow-1
state  out  2  IDLE=0, REC=1, PLAY=2, PAUSE=3

Behaviour:
- All buttons are rising-edge detected via a registered copy. Action takes effect on the clock edge that first samples the button high; outputs change on that same edge.
- Reset, and the first edge with reset high: state=IDLE, addr=0, end_addr=0, full=0, speed index=0 (slow=1, fast=1), slowmethod=0, phase=0, record=0, play=0. Button history registers load the current button levels, so a held button does not fire after reset.
- Same-cycle button priority: stop > record > play. Speed and method buttons are independent of transport buttons.
- IDLE:
  - record edge -> REC; addr=0, end_addr=0, full=0.
  - play edge with end_addr!=0 -> PLAY; addr=0, phase=0.
  - play edge with end_addr==0 -> ignored.
- REC, on each sample_tick:
  - end_addr=addr+1, then addr+1.
  - If addr==MAX_ADDR at the tick: end_addr=MAX_ADDR+1 (saturated to all-ones), full=1, state -> IDLE, addr=0.
  - stop edge -> IDLE, addr=0; end_addr is kept.
  - play edge is ignored.
- PLAY, on each sample_tick:
  - If phase<slow-1: phase+1 and addr holds.
  - Otherwise: phase=0 and addr=addr+fast.
  - If the new address is >= end_addr: with LOOP=1, addr=new-end_addr; with LOOP=0, state -> IDLE and addr=0.
  - Address arithmetic is ADDR_W+1 bits wide; no silent wrap.
- PLAY/PAUSE:
  - play edge toggles PLAY<->PAUSE. In PAUSE, sample_tick is ignored and addr/phase hold.
  - stop edge -> IDLE, addr=0, phase=0.
  - record edge in PLAY or PAUSE is ignored.
- Speed index: signed, range -(MAX_RATE-1)..+(MAX_RATE-1), saturating.
  - index>=0: fast=index+1, slow=1.
  - index<0: slow=-index+1, fast=1.
  - Faster and slower on the same cycle: no change.
  - A speed change during PLAY takes effect immediately; phase is cleared to 0 if it is >= the new slow.
- btn_method edge toggles slowmethod in any state.
- sample_tick coincident with a transport button edge: the button action wins and the tick is discarded.

Test Plan:
- Reset held 3 cycles with btn_play high -> state=0, addr=0, slow=1, fast=1. Releasing and re-pressing play with end_addr=0 -> state stays 0.
- Record press, 5 sample_ticks, stop -> state REC then IDLE, addr 0..5 then 0, end_addr=5, full=0.
- end_addr=5, play, index=0, 5 ticks -> addr 0,1,2,3,4 then IDLE with addr=0. Repeat with LOOP=1 -> addr returns to 0 and state stays PLAY.
- Slower pressed twice (slow=3), play, 7 ticks -> phase 0,1,2,0,1,2,0 and addr 0,0,0,1,1,1,2.
- Faster pressed 9 times with MAX_RATE=8 -> fast saturates at 8. Play with end_addr=20 -> addr 0,8,16 then IDLE.
- Record with MAX_ADDR=3, 4 ticks -> full=1, state IDLE, end_addr=4. Stop+record+play on the same cycle during PLAY -> IDLE. Play during PAUSE with tick on the same cycle -> PLAY, addr unchanged.
